// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port RAM between the CPU memory path and a loader/debug
// port. Each access is a req/ack handshake: the winner's command is latched,
// the RAM strobe is held for MEM_LAT cycles, and a one-cycle ack is returned
// together with the registered read data.
//
// Ports
//   clock, clear_n            clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata     CPU request (held until cpu_ack)
//   cpu_ack                   one-cycle completion pulse to the CPU
//   ld_req/we/addr/wdata      loader request (held until ld_ack)
//   ld_ack                    one-cycle completion pulse to the loader
//   rdata                     read data, valid in the ack cycle, held after
//   mem_read/mem_write        RAM strobes
//   mem_addr/mem_wdata        RAM address / write data
//   mem_rdata                 RAM read data
//   busy                      transaction in progress (state != IDLE)
//   grant                     owner of current/last transaction (1 = loader)
//
// Build option
//   ARB_CPU_PRIORITY_EN  defined: CPU always wins a tie (fixed priority).
//                        undefined: round-robin on ties (default).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ram_arbiter #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 1    // legal range 1..15
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              grant
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

   logic [1:0]        state_q,      state_d;
   logic [3:0]        cnt_q,        cnt_d;
   logic              grant_q,      grant_d;
   logic              last_grant_q, last_grant_d;
   logic              mem_read_q,   mem_read_d;
   logic              mem_write_q,  mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
   logic              cpu_ack_q,    cpu_ack_d;
   logic              ld_ack_q,     ld_ack_d;
   logic [DATA_W-1:0] rdata_q,      rdata_d;
   logic              busy_q,       busy_d;

   // Winner selection for the IDLE cycle. Only meaningful when some req is up.
   logic pick_ld;
   logic win_we;

`ifdef ARB_CPU_PRIORITY_EN
   // CPU always wins; last_grant is still tracked but plays no part here.
   assign pick_ld = ld_req & ~cpu_req;
`else
   // On a tie the loader wins only if the CPU had the previous transaction.
   assign pick_ld = ld_req & (~cpu_req | ~last_grant_q);
`endif

   assign win_we = pick_ld ? ld_we : cpu_we;

   // NOTE: every next-state signal is given a default before the case so no
   // path leaves it unassigned; otherwise a latch would be inferred.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_ack_d    = 1'b0;
      ld_ack_d     = 1'b0;
      rdata_d      = rdata_q;
      busy_d       = busy_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req || ld_req) begin
               // The address/data registers double as the command latch, so
               // requester inputs are ignored until the next IDLE cycle.
               grant_d      = pick_ld;
               last_grant_d = pick_ld;
               mem_addr_d   = pick_ld ? ld_addr  : cpu_addr;
               mem_wdata_d  = pick_ld ? ld_wdata : cpu_wdata;
               mem_read_d   = ~win_we;
               mem_write_d  = win_we;
               busy_d       = 1'b1;
               cnt_d        = 4'd0;
               state_d      = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            if (cnt_q == LAT_LAST) begin
               if (mem_read_q) begin
                  rdata_d = mem_rdata;
               end
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               cpu_ack_d   = ~grant_q;
               ld_ack_d    = grant_q;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         ST_RESP: begin
            busy_d  = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
         end

         default: begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            busy_d      = 1'b0;
            cnt_d       = 4'd0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its neighbours, independent of order.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;    // CPU wins the first tie after reset
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         ld_ack_q     <= 1'b0;
         rdata_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_ack_q    <= cpu_ack_d;
         ld_ack_q     <= ld_ack_d;
         rdata_q      <= rdata_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign ld_ack    = ld_ack_q;
   assign rdata     = rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign grant     = grant_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM between two requesters: the CPU memory path (control unit read/write strobes, MAR address, MDR data) and a loader/debug port that preloads programs and inspects memory.
- Sits between both requesters and the RAM.
- Serialises accesses with a req/ack handshake, drives the RAM strobes for a programmable latency, and returns read data in a shared registered output.

Parameters:
- ADDR_W, 9: RAM word-address width.
- DATA_W, 32: data word width.
- MEM_LAT, 1: cycles the RAM strobe is held before read data is valid; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- ld_req  in  1  loader access request; held until ld_ack.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  ADDR_W  loader word address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ack  out  1  one-cycle completion pulse to the loader.
- rdata  out  DATA_W  read data; valid in the ack cycle.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  transaction in progress (state is not IDLE).
- grant  out  1  owner of the current or last transaction: 0 = CPU, 1 = loader.

Behaviour:
- One clock; reset is asynchronous and active-low.
- All outputs are registered. Reset values:
  - all outputs 0 (including rdata);
  - state IDLE, latency counter 0;
  - internal last_grant = 1, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant it.
  - If both req, grant the requester not equal to last_grant (round-robin).
  - On grant, latch we/addr/wdata of the winner, set grant and last_grant, go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata hold the latched values.
  - mem_read = ~we and mem_write = we, asserted for exactly MEM_LAT consecutive cycles; the counter runs 0..MEM_LAT-1.
  - In the last ACCESS cycle, a read captures mem_rdata into rdata at the clock edge.
  - Then go to RESP.
- RESP:
  - Strobes deasserted.
  - Winner's ack = 1 for exactly one cycle; the other ack stays 0.
  - Next state is IDLE.
- Latency: req sampled in IDLE at cycle n -> ACCESS in cycles n+1..n+MEM_LAT -> ack in cycle n+MEM_LAT+1. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Writes leave rdata unchanged.
- rdata holds its value until the next read completes.
- A requester must drop req in the cycle after its ack; a req still high in IDLE is a new request.
- A req dropped mid-transaction does not abort: the access completes and the ack still pulses. Inputs changing after the grant are ignored because they are latched.
- If a request arrives while busy, it waits. The starved requester wins the next IDLE cycle whenever both are requesting.
- cpu_ack and ld_ack are never high in the same cycle.
- mem_read and mem_write are never high in the same cycle.
- clear_n low at any point, including mid-ACCESS: strobes, acks and busy drop immediately and asynchronously; state returns to IDLE. The interrupted transaction is lost and no ack is issued.
- busy = 1 in ACCESS and RESP.

Optional Feature:
- Macro: ARB_CPU_PRIORITY_EN.
- Defined: fixed priority, the CPU always wins when both request. last_grant is still updated but ignored. The loader is served only in IDLE cycles with cpu_req = 0.
- Undefined (default): round-robin as described in Behaviour.

Test Plan:
- Single read, MEM_LAT=1, RAM[0x010]=0xDEADBEEF; cpu_req=1, cpu_we=0, cpu_addr=0x010 at cycle 0 -> mem_read high and mem_addr=0x010 in cycle 1 only; cpu_ack=1 and rdata=0xDEADBEEF in cycle 2; ld_ack=0 throughout.
- Loader write then CPU read: ld write 0x12345678 to 0x1FF, then cpu read 0x1FF -> one mem_write pulse with mem_wdata=0x12345678; the later cpu_ack shows rdata=0x12345678; grant=1 then 0.
- Tie, round-robin: both req held continuously, each read from a distinct address -> grants alternate CPU, loader, CPU, loader; acks are 3 cycles apart at MEM_LAT=1; never both acks high.
- Latency: MEM_LAT=4, cpu read of 0x005 -> mem_read high for exactly 4 cycles; cpu_ack in cycle 5 after sampling; busy high for 5 cycles.
- Reset mid-access: MEM_LAT=4, clear_n low during the 2nd ACCESS cycle -> mem_read, busy and acks drop immediately with no ack; after release, a fresh cpu read completes normally with the CPU granted first on a tie.
- With ARB_CPU_PRIORITY_EN: both req held for 3 transactions -> all 3 granted to the CPU; the loader is granted only after cpu_req drops.
